// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
//   Instruction fetch stage. A PC register addresses a combinational
//   instruction memory. Each fetched word is pushed into a small prefetch
//   FIFO, and decode drains that FIFO through a valid/ready handshake.
//   A taken branch reloads the PC and flushes the FIFO. When the FIFO is
//   full and decode is not popping, fetch stalls.
//
//   Optional feature: define FETCH_PERF_EN to add the 16-bit saturating
//   counters perf_fetch_cnt and perf_stall_cnt.
//
//   The reset input rst is asynchronous and active-low.

module fetch_queue_unit #(
   parameter int unsigned          ADDR_W   = 8,
   parameter int unsigned          INSTR_W  = 16,
   parameter int unsigned          DEPTH    = 4,
   parameter logic [ADDR_W-1:0]    RESET_PC = '0
) (
   input  logic                clk,
   input  logic                rst,
   output logic [ADDR_W-1:0]   instr_addr,
   input  logic [INSTR_W-1:0]  instr,
   input  logic                branch_taken,
   input  logic [ADDR_W-1:0]   branch_target,
   output logic [INSTR_W-1:0]  out_instr,
   output logic                out_valid,
   input  logic                out_ready
`ifdef FETCH_PERF_EN
   ,
   output logic [15:0]         perf_fetch_cnt,
   output logic [15:0]         perf_stall_cnt
`endif
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [ADDR_W-1:0]  pc;
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic [CNT_W-1:0]   count;
   logic [INSTR_W-1:0] mem [DEPTH];

   logic pop;
   logic fetch;
   logic full;

   // The handshake retires the head entry. Fetch is blocked only by a
   // redirect, or by a full FIFO that is not popping this cycle.
   assign full  = (count == FULL_CNT);
   assign pop   = out_valid & out_ready;
   assign fetch = ~branch_taken & (~full | pop);

   // The address to memory is the PC register itself, with no
   // combinational path from any input.
   assign instr_addr = pc;

   // PC: a redirect has priority. Otherwise the PC advances on each fetch
   // and wraps modulo 2**ADDR_W.
   // NOTE: sequential state uses non-blocking assignments so that every
   // register samples pre-edge values; blocking here would create ordering races.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc <= RESET_PC;
      end else if (branch_taken) begin
         pc <= branch_target;
      end else if (fetch) begin
         pc <= pc + ADDR_W'(1);
      end
   end

   // FIFO bookkeeping: a redirect flushes. Otherwise push on fetch and
   // pop on handshake. Occupancy stays in the range 0..DEPTH by construction.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (branch_taken) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (fetch) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)   rd_ptr <= rd_ptr + PTR_W'(1);
         unique case ({fetch, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array: write the fetched word at the tail.
   // NOTE: the data array is deliberately left out of reset. Occupancy and
   // pointers define validity, and the output is gated, so stale contents
   // are never visible.
   always_ff @(posedge clk) begin
      if (fetch) begin
         mem[wr_ptr] <= instr;
      end
   end

   // Present the head entry to decode. When the FIFO is empty the output
   // is forced to zero, so nothing undefined leaks out.
   // NOTE: every output of a combinational block gets a default first,
   // which keeps any path from inferring a latch.
   always_comb begin
      out_valid = 1'b0;
      out_instr = '0;
      if (count != '0) begin
         out_valid = 1'b1;
         out_instr = mem[rd_ptr];
      end
   end

`ifdef FETCH_PERF_EN
   // Performance counters: count fetch edges, and stall edges (no fetch
   // and no redirect). Both saturate at all-ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_fetch_cnt <= '0;
         perf_stall_cnt <= '0;
      end else begin
         if (fetch && (perf_fetch_cnt != 16'hFFFF)) begin
            perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
         end
         if (!fetch && !branch_taken && (perf_stall_cnt != 16'hFFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_queue_unit.sv
// tb_fetch_queue_unit
//   Directed bench for fetch_queue_unit with ADDR_W=8, INSTR_W=16, DEPTH=4
//   and RESET_PC=0. The memory model returns {addr, ~addr}. Inputs change
//   1 time unit after a rising edge, and outputs are sampled at that same
//   point, well away from the next edge.

module tb_fetch_queue_unit;

   logic        clk;
   logic        rst;
   logic [7:0]  instr_addr;
   logic [15:0] instr;
   logic        branch_taken;
   logic [7:0]  branch_target;
   logic [15:0] out_instr;
   logic        out_valid;
   logic        out_ready;
`ifdef FETCH_PERF_EN
   logic [15:0] perf_fetch_cnt;
   logic [15:0] perf_stall_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   fetch_queue_unit #(
      .ADDR_W   (8),
      .INSTR_W  (16),
      .DEPTH    (4),
      .RESET_PC (8'h00)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .instr_addr    (instr_addr),
      .instr         (instr),
      .branch_taken  (branch_taken),
      .branch_target (branch_target),
      .out_instr     (out_instr),
      .out_valid     (out_valid),
      .out_ready     (out_ready)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch_cnt(perf_fetch_cnt),
      .perf_stall_cnt(perf_stall_cnt)
`endif
   );

   // Combinational instruction memory model.
   assign instr = {instr_addr, ~instr_addr};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      n_checks++;
      assert (observed === expected)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   // Advance one rising edge, then settle 1 unit past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic [7:0] addr,
                            input logic vld, input logic [15:0] ins);
      check({tag, ".addr"},  32'(instr_addr), 32'(addr));
      check({tag, ".valid"}, 32'(out_valid),  32'(vld));
      check({tag, ".instr"}, 32'(out_instr),  32'(ins));
   endtask

   // Assert reset mid-cycle, check the outputs clear with no clock edge,
   // then release reset.
   task automatic do_reset(input string tag);
      rst = 1'b0;
      #2;
      check_out(tag, 8'h00, 1'b0, 16'h0000);
      @(negedge clk);
      rst = 1'b1;
      #1;
   endtask

   initial begin
      rst           = 1'b0;
      branch_taken  = 1'b0;
      branch_target = 8'h00;
      out_ready     = 1'b1;
      #3;

      // ---- Reset state --------------------------------------------------
      do_reset("reset0");
      check_out("reset0_rel", 8'h00, 1'b0, 16'h0000);

      // ---- Streaming with out_ready=1 -----------------------------------
      step(); check_out("stream1", 8'h01, 1'b1, 16'h00FF);
      step(); check_out("stream2", 8'h02, 1'b1, 16'h01FE);
      step(); check_out("stream3", 8'h03, 1'b1, 16'h02FD);
      step(); check_out("stream4", 8'h04, 1'b1, 16'h03FC);

      // ---- Asynchronous reset mid-operation -----------------------------
      out_ready = 1'b0;
      do_reset("reset_mid");

      // ---- Backpressure from reset ---------------------------------------
      step(); check_out("bp1", 8'h01, 1'b1, 16'h00FF);
      step(); step(); step();
      check_out("bp4", 8'h04, 1'b1, 16'h00FF);
      step(); check_out("bp_full", 8'h04, 1'b1, 16'h00FF);
      step(); check_out("bp_full2", 8'h04, 1'b1, 16'h00FF);
      out_ready = 1'b1;
      // Full with pop: fetch proceeds, drain in order without gap.
      step(); check_out("drain1", 8'h05, 1'b1, 16'h01FE);
      step(); check_out("drain2", 8'h06, 1'b1, 16'h02FD);
      step(); check_out("drain3", 8'h07, 1'b1, 16'h03FC);
      step(); check_out("drain4", 8'h08, 1'b1, 16'h04FB);
      step(); check_out("drain5", 8'h09, 1'b1, 16'h05FA);

      // ---- PC wrap via redirect to 0xFE ---------------------------------
      branch_taken  = 1'b1;
      branch_target = 8'hFE;
      step(); check_out("wrap_redir", 8'hFE, 1'b0, 16'h0000);
      branch_taken = 1'b0;
      step(); check_out("wrap1", 8'hFF, 1'b1, 16'hFE01);
      step(); check_out("wrap2", 8'h00, 1'b1, 16'hFF00);
      step(); check_out("wrap3", 8'h01, 1'b1, 16'h00FF);

      // ---- Redirect with 3 entries queued and a pop pending --------------
      do_reset("reset_br");
      out_ready = 1'b0;
      step(); step(); step();
      check_out("br_fill", 8'h03, 1'b1, 16'h00FF);
      out_ready     = 1'b1;
      branch_taken  = 1'b1;
      branch_target = 8'h40;
      step(); check_out("br_flush", 8'h40, 1'b0, 16'h0000);
      // Held redirect: each edge reloads the PC, and there is still no fetch.
      branch_target = 8'h80;
      step(); check_out("br_hold", 8'h80, 1'b0, 16'h0000);
      branch_target = 8'h40;
      step(); check_out("br_hold2", 8'h40, 1'b0, 16'h0000);
      branch_taken = 1'b0;
      step(); check_out("br_tgt", 8'h41, 1'b1, 16'h40BF);
      step(); check_out("br_tgt2", 8'h42, 1'b1, 16'h41BE);

`ifdef FETCH_PERF_EN
      // ---- Performance counters: 10 edges with out_ready=0 ---------------
      out_ready = 1'b0;
      do_reset("reset_perf");
      check("perf_fetch_rst", 32'(perf_fetch_cnt), 32'd0);
      check("perf_stall_rst", 32'(perf_stall_cnt), 32'd0);
      for (int i = 0; i < 10; i++) step();
      check("perf_fetch", 32'(perf_fetch_cnt), 32'd4);
      check("perf_stall", 32'(perf_stall_cnt), 32'd6);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
